morse_receiver: RTL and testbench
=================================

Name: morse_receiver

Overview:
- Receive side of the lab Morse link: samples a serial on/off line once per symbol tick and measures mark/space run lengths.
- Classifies each mark as dot or dash and assembles up to 4 elements per letter.
- On an inter-letter gap, decodes the assembled letter to the 3-bit S..Z code used by the transmitter's switch selection, or flags an error.
- Sits after a tick generator (0.5 s pulser at board level; free-running in simulation) and drives LEDs/HEX at top level.

Parameters:
- MAX_ELEMS, 4, maximum dots/dashes per letter.
- DASH_MIN, 2, minimum mark length in ticks classified as dash; marks of 1 tick are dots.
- MARK_MAX, 3, longest legal mark in ticks; longer marks set error.
- LETTER_GAP, 3, space length in ticks that terminates a letter.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- tick  input  1  one-cycle symbol-period strobe; line_in is sampled only when tick=1.
- line_in  input  1  serial Morse line, 1=mark (tone/LED on), 0=space.
- letter  output  3  decoded code: 000=S 001=T 010=U 011=V 100=W 101=X 110=Y 111=Z; holds last value.
- valid  output  1  one-cycle pulse: letter/error updated.
- error  output  1  qualifies valid: 1 = illegal mark length, too many elements, or pattern not in S..Z; holds until next valid.
- busy  output  1  1 while a letter is being assembled (state MARK or SPACE).

Behaviour:
- Clock and reset: single clock, synchronous active-high reset. Reset clears all state; mid-letter reset discards the partial letter.
- Reset values: letter=000, valid=0, error=0, busy=0, state=IDLE, run counter=0, element count=0, pattern=0.
- Sampling: all state updates happen on cycles with tick=1, except the EMIT→IDLE transition and the valid pulse.
- Run counter: 3-bit, saturates at 7, reloaded to 1 on each mark/space transition.
- IDLE:
  - tick & line_in=0: stay; leading spaces are ignored.
  - tick & line_in=1: go to MARK, run=1.
- MARK:
  - tick & line_in=1: run++ (saturating).
  - tick & line_in=0: classify the mark and go to SPACE, run=1.
  - Classification: run=1 → dot(0); DASH_MIN≤run≤MARK_MAX → dash(1); run>MARK_MAX → set bad flag.
  - Store the element at pattern[count] (first element at bit 0), then count++.
  - If count is already MAX_ELEMS, set bad flag and do not store.
- SPACE:
  - tick & line_in=1 with run<LETTER_GAP: intra-letter gap; go to MARK, run=1. A 2-tick gap is tolerated as intra-letter.
  - tick & line_in=0: run++. When run reaches LETTER_GAP, go to EMIT.
- EMIT (one cycle, independent of tick):
  - Register valid=1 and go to IDLE.
  - If bad, or the pattern/count is not in the table: error=1 and letter unchanged. Otherwise error=0 and letter=code.
  - Clear pattern, count and bad.
- Decode table (count:pattern, bit0 = first element):
  - S 3:000
  - T 1:1
  - U 3:100
  - V 4:1000
  - W 3:110
  - X 4:1001
  - Y 4:1101
  - Z 4:0011
- valid timing: asserts exactly one clock after the tick on which the letter gap completes; deasserts the following clock.
- Space after EMIT: extra space ticks (word gaps) produce no further valid pulses.
- Stuck mark: a line held at 1 saturates the counter. The error is reported only once the mark ends and a full letter gap follows.
- tick=0 cycles: everything holds, except that EMIT still completes.

Test Plan:
- tick every cycle; line_in 1,0,1,0,1,0,0,0 (S) → valid pulses once, 1 cycle after the 3rd trailing 0; letter=000, error=0.
- tick every 4th cycle; line_in per tick 1,1,1,0,1,0,1,0,1,1,1,0,0,0 (X: -..-) → valid once, letter=101, error=0. busy=1 from the first mark tick through EMIT.
- line_in 1,0,1,0,1,0,1,0,1,0,0,0 (5 dots) → valid=1, error=1; letter keeps its previous value.
- line_in 1,1,1,1,0,0,0 (4-tick mark) → valid=1, error=1.
- line_in 1,0,1,1,0,0,0 (.- = A, not in table) → error=1. A following T (1,1,1,0,0,0) → letter=001, error=0.
- reset asserted for 1 cycle mid-Y after 1,1,1,0,1 → busy=0 and no valid. A following T decodes to 001 with no leftover elements.

Source files
------------

// File: rtl/morse_receiver.sv
// Morse receive path: samples line_in on each symbol tick, measures mark and
// space run lengths, assembles up to MAX_ELEMS dots/dashes and decodes the
// letter (S..Z) once a full inter-letter gap has been seen.
module morse_receiver #(
  parameter int MAX_ELEMS  = 4,
  parameter int DASH_MIN   = 2,
  parameter int MARK_MAX   = 3,
  parameter int LETTER_GAP = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       line_in,
  output logic [2:0] letter,
  output logic       valid,
  output logic       error,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, MARK, SPACE, EMIT} state_t;

  state_t     state_q, state_d;
  logic [2:0] run_q, run_d;
  logic [2:0] cnt_q, cnt_d;
  logic [3:0] pat_q, pat_d;
  logic       bad_q, bad_d;
  logic [2:0] letter_q, letter_d;
  logic       valid_q, valid_d;
  logic       error_q, error_d;

  logic [2:0] run_inc;
  logic [2:0] code;
  logic       hit;

  // Saturating run-length increment so a stuck mark parks at 7.
  assign run_inc = (run_q == 3'd7) ? 3'd7 : run_q + 3'd1;

  // Letter table lookup; bit 0 of the pattern is the first element sent.
  always_comb begin
    hit  = 1'b1;
    code = 3'd0;
    case ({cnt_q, pat_q})
      {3'd3, 4'b0000}: code = 3'd0; // S ...
      {3'd1, 4'b0001}: code = 3'd1; // T -
      {3'd3, 4'b0100}: code = 3'd2; // U ..-
      {3'd4, 4'b1000}: code = 3'd3; // V ...-
      {3'd3, 4'b0110}: code = 3'd4; // W .--
      {3'd4, 4'b1001}: code = 3'd5; // X -..-
      {3'd4, 4'b1101}: code = 3'd6; // Y -.--
      {3'd4, 4'b0011}: code = 3'd7; // Z --..
      default:         hit  = 1'b0;
    endcase
  end

  // Next-state logic: everything advances on tick, except EMIT which always
  // completes in one cycle and publishes the decoded result.
  always_comb begin
    state_d  = state_q;
    run_d    = run_q;
    cnt_d    = cnt_q;
    pat_d    = pat_q;
    bad_d    = bad_q;
    letter_d = letter_q;
    error_d  = error_q;
    valid_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (tick && line_in) begin
          state_d = MARK;
          run_d   = 3'd1;
        end
      end
      MARK: begin
        if (tick) begin
          if (line_in) begin
            run_d = run_inc;
          end else begin
            state_d = SPACE;
            run_d   = 3'd1;
            if (run_q > 3'(MARK_MAX)) bad_d = 1'b1;
            if (cnt_q == 3'(MAX_ELEMS)) begin
              bad_d = 1'b1;
            end else begin
              // Dash is any legal mark of DASH_MIN ticks or more.
              pat_d[cnt_q[1:0]] = (run_q >= 3'(DASH_MIN));
              cnt_d = cnt_q + 3'd1;
            end
          end
        end
      end
      SPACE: begin
        if (tick) begin
          if (line_in) begin
            state_d = MARK;
            run_d   = 3'd1;
          end else begin
            run_d = run_inc;
            if (run_inc >= 3'(LETTER_GAP)) state_d = EMIT;
          end
        end
      end
      EMIT: begin
        state_d = IDLE;
        valid_d = 1'b1;
        if (bad_q || !hit) begin
          error_d = 1'b1;
        end else begin
          error_d  = 1'b0;
          letter_d = code;
        end
        run_d = 3'd0;
        cnt_d = 3'd0;
        pat_d = 4'd0;
        bad_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous reset; reset drops any partial letter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      run_q    <= 3'd0;
      cnt_q    <= 3'd0;
      pat_q    <= 4'd0;
      bad_q    <= 1'b0;
      letter_q <= 3'd0;
      valid_q  <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      run_q    <= run_d;
      cnt_q    <= cnt_d;
      pat_q    <= pat_d;
      bad_q    <= bad_d;
      letter_q <= letter_d;
      valid_q  <= valid_d;
      error_q  <= error_d;
    end
  end

  assign letter = letter_q;
  assign valid  = valid_q;
  assign error  = error_q;
  assign busy   = (state_q != IDLE);

endmodule

// File: tb/tb_morse_receiver.sv
// Directed bench for morse_receiver: expected {letter,error} pairs are queued
// when a letter is sent and popped/compared whenever valid pulses.
module tb_morse_receiver;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick = 1'b0;
  logic       line_in = 1'b0;
  logic [2:0] letter;
  logic       valid, error, busy;

  int tests = 0;
  int fails = 0;
  int nvalid = 0;
  int exp_valid = 0;
  int per = 1;
  logic prev_valid = 1'b0;
  logic [3:0] exp_q[$];

  morse_receiver dut (
    .clk(clk), .reset(reset), .tick(tick), .line_in(line_in),
    .letter(letter), .valid(valid), .error(error), .busy(busy)
  );

  always #5 clk = ~clk;

  // Scoreboard side: every valid pulse must match the oldest queued result.
  always @(negedge clk) begin
    if (valid) begin
      logic [3:0] e;
      nvalid++;
      tests++;
      assert (prev_valid === 1'b0) else begin
        fails++; $error("FAIL valid_width: got 2+ cycle pulse expected 1 cycle");
      end
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $error("FAIL unexpected_valid: got letter=%b error=%b expected no pulse", letter, error);
      end else begin
        e = exp_q.pop_front();
        assert ({letter, error} === e) else begin
          fails++;
          $error("FAIL result: got letter=%b error=%b expected letter=%b error=%b",
                 letter, error, e[3:1], e[0]);
        end
      end
    end
    prev_valid = valid;
  end

  // One symbol: tick high for one cycle, then per-1 quiet cycles.
  task automatic tk(input logic b);
    @(negedge clk);
    line_in = b;
    tick = 1'b1;
    for (int i = 1; i < per; i++) begin
      @(negedge clk);
      tick = 1'b0;
    end
  endtask

  task automatic send(input string s);
    for (int i = 0; i < s.len(); i++) tk(s[i] == "1");
  endtask

  task automatic expect_letter(input logic [2:0] l, input logic e);
    exp_q.push_back({l, e});
    exp_valid++;
  endtask

  // Quiet period long enough for EMIT and the valid pulse, then confirm
  // every queued result was produced and no extra pulses appeared.
  task automatic flush(input string tag);
    repeat (6) begin
      @(negedge clk);
      tick = 1'b0;
      line_in = 1'b0;
    end
    tests++;
    assert (exp_q.size() == 0 && nvalid == exp_valid) else begin
      fails++;
      $error("FAIL %s: got %0d pulses (%0d pending) expected %0d pulses", tag,
             nvalid, exp_q.size(), exp_valid);
    end
  endtask

  task automatic check1(input string tag, input logic got, input logic expv);
    tests++;
    assert (got === expv) else begin
      fails++; $error("FAIL %s: got %b expected %b", tag, got, expv);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    // Reset state
    tests++;
    assert ({letter, valid, error, busy} === 6'b000_000) else begin
      fails++; $error("FAIL reset_state: got %b expected 000000", {letter, valid, error, busy});
    end
    reset = 1'b0;

    // S with a tick every cycle
    per = 1;
    expect_letter(3'b000, 1'b0);
    send("10101000");
    flush("s_every_tick");

    // X with a tick every 4th cycle; busy across the letter
    per = 4;
    expect_letter(3'b101, 1'b0);
    send("1");
    check1("busy_first_mark", busy, 1'b1);
    send("11010101");
    check1("busy_mid_letter", busy, 1'b1);
    send("11000");
    flush("x_slow_tick");
    check1("busy_after_x", busy, 1'b0);

    // Five dots: too many elements, letter holds X
    per = 1;
    expect_letter(3'b101, 1'b1);
    send("101010101000");
    flush("five_dots");

    // 4-tick mark is illegal
    expect_letter(3'b101, 1'b1);
    send("1111000");
    flush("long_mark");

    // A (.-) is not in the table, then T recovers
    expect_letter(3'b101, 1'b1);
    send("1011000");
    flush("letter_a");
    expect_letter(3'b001, 1'b0);
    send("111000");
    flush("t_after_a");

    // Reset mid-Y discards the partial letter
    send("11101");
    @(negedge clk);
    tick = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check1("busy_after_reset", busy, 1'b0);
    tests++;
    assert (letter === 3'b000) else begin
      fails++; $error("FAIL letter_after_reset: got %b expected 000", letter);
    end
    flush("no_valid_after_reset");
    expect_letter(3'b001, 1'b0);
    send("111000");
    flush("t_after_reset");

    // Word gap: extra spaces give no further pulses
    send("0000000");
    flush("word_gap");

    // Two-tick gaps stay inside the letter
    expect_letter(3'b000, 1'b0);
    send("1001001000");
    flush("two_tick_gap");

    // V, Z, W, U, Y across the table
    expect_letter(3'b011, 1'b0);
    send("10101011000");
    flush("letter_v");
    expect_letter(3'b111, 1'b0);
    send("110110101000");
    flush("letter_z");
    expect_letter(3'b100, 1'b0);
    send("10110110000");
    flush("letter_w");
    expect_letter(3'b010, 1'b0);
    send("1010110000");
    flush("letter_u");
    expect_letter(3'b110, 1'b0);
    send("11010110110000");
    flush("letter_y");

    // Stuck mark saturates; error only once the gap follows, letter holds Y
    send("1111111111");
    check1("stuck_busy", busy, 1'b1);
    check1("stuck_no_valid", valid, 1'b0);
    expect_letter(3'b110, 1'b1);
    send("000");
    flush("stuck_mark");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
